// File: rtl/timer_multi_if.sv
// Bundle of per-channel control and status lines for timer_multi.
// master drives load/data/mode/clear; slave (the timer) drives out/pulse/busy.
interface timer_multi_if #(
    parameter int unsigned WIDTH    = 10,
    parameter int unsigned CHANNELS = 4
);
    logic [CHANNELS-1:0]       timer_load;
    logic [CHANNELS*WIDTH-1:0] timer_data;
    logic [CHANNELS-1:0]       timer_mode;
    logic [CHANNELS-1:0]       timer_clear;
    logic [CHANNELS-1:0]       timer_out;
    logic [CHANNELS-1:0]       timer_pulse;
    logic [CHANNELS-1:0]       timer_busy;

    modport master (
        output timer_load, timer_data, timer_mode, timer_clear,
        input  timer_out, timer_pulse, timer_busy
    );

    modport slave (
        input  timer_load, timer_data, timer_mode, timer_clear,
        output timer_out, timer_pulse, timer_busy
    );
endinterface

// File: rtl/timer_multi.sv
// Multi-channel programmable down-timer: per-channel prescaler, one-shot or
// periodic reload, sticky expiry flag with clear and a single-cycle pulse.
module timer_multi #(
    parameter int unsigned FREQ     = 5,
    parameter int unsigned WIDTH    = 10,
    parameter int unsigned CHANNELS = 4
) (
    input  logic         timer_clock,
    input  logic         timer_rstn,
    timer_multi_if.slave bus
);
    localparam int unsigned   PW     = (FREQ > 1) ? $clog2(FREQ) : 1;
    localparam logic [PW-1:0] PreMax = PW'(FREQ - 1);

    typedef enum logic [1:0] {StIdle, StLoad, StCount, StDone} state_e;

    state_e              r_state  [CHANNELS];
    logic [PW-1:0]       r_pre    [CHANNELS];
    logic [WIDTH-1:0]    r_cnt    [CHANNELS];
    logic [WIDTH-1:0]    r_reload [CHANNELS];
    logic [CHANNELS-1:0] r_mode;
    logic [CHANNELS-1:0] r_out;
    logic [CHANNELS-1:0] r_pulse;
    logic [CHANNELS-1:0] r_busy;

    logic [CHANNELS-1:0] w_active;
    logic [CHANNELS-1:0] w_tick;
    logic [CHANNELS-1:0] w_expire;

    // The release edge (leaving LOAD) is itself the first prescaler edge;
    // a zero count can only be seen there and expires immediately.
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            w_active[i] = 1'b0;
            w_tick[i]   = 1'b0;
            w_expire[i] = 1'b0;
            if (!bus.timer_load[i] && (r_state[i] == StLoad || r_state[i] == StCount)) begin
                w_active[i] = 1'b1;
                if (r_cnt[i] == '0) begin
                    w_expire[i] = 1'b1;
                end else if (r_pre[i] == PreMax) begin
                    w_tick[i]   = 1'b1;
                    w_expire[i] = (r_cnt[i] == WIDTH'(1));
                end
            end
        end
    end

    always_ff @(posedge timer_clock or negedge timer_rstn) begin
        if (!timer_rstn) begin
            for (int i = 0; i < CHANNELS; i++) begin
                r_state[i]  <= StIdle;
                r_pre[i]    <= '0;
                r_cnt[i]    <= '0;
                r_reload[i] <= '0;
            end
            r_mode  <= '0;
            r_out   <= '0;
            r_pulse <= '0;
            r_busy  <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                r_pulse[i] <= 1'b0;
                if (bus.timer_load[i]) begin
                    r_state[i]  <= StLoad;
                    r_reload[i] <= bus.timer_data[i*WIDTH +: WIDTH];
                    r_cnt[i]    <= bus.timer_data[i*WIDTH +: WIDTH];
                    r_mode[i]   <= bus.timer_mode[i];
                    r_pre[i]    <= '0;
                    r_out[i]    <= 1'b0;
                    r_busy[i]   <= 1'b0;
                end else begin
                    if (bus.timer_clear[i]) begin
                        r_out[i] <= 1'b0;
                    end
                    if (w_active[i]) begin
                        if (w_expire[i]) begin
                            r_out[i]   <= 1'b1;
                            r_pulse[i] <= 1'b1;
                            // Periodic with a zero reload degrades to one-shot.
                            if (r_mode[i] && (r_reload[i] != '0)) begin
                                r_state[i] <= StCount;
                                r_cnt[i]   <= r_reload[i];
                                r_pre[i]   <= '0;
                                r_busy[i]  <= 1'b1;
                            end else begin
                                r_state[i] <= StDone;
                                r_busy[i]  <= 1'b0;
                            end
                        end else begin
                            r_state[i] <= StCount;
                            r_busy[i]  <= 1'b1;
                            if (w_tick[i]) begin
                                r_pre[i] <= '0;
                                r_cnt[i] <= r_cnt[i] - WIDTH'(1);
                            end else begin
                                r_pre[i] <= r_pre[i] + PW'(1);
                            end
                        end
                    end
                end
            end
        end
    end

    assign bus.timer_out   = r_out;
    assign bus.timer_pulse = r_pulse;
    assign bus.timer_busy  = r_busy;
endmodule
